// File: rtl/reg_file_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_file_checker
// Description : End-of-test register-file checker. A start pulse opens a
//               fixed-length run window; afterwards every core register is
//               read back one per cycle and compared with an expected table.
//               Each mismatch is reported through a valid/ready handshake,
//               and a pass/fail verdict is held once the scan completes.
// Ports       : clock, reset (async, active high), start
//               exp_wr_en/exp_wr_index/exp_wr_data : expected-table load
//               rf_read_index -> / rf_read_data <-   : core RF read port
//               mm_valid/mm_ready, mm_index/mm_expected/mm_actual : reports
//               busy, done, test_passed, mm_count  : run status
// Options     : CHECKER_MASK_EN adds exp_wr_mask and a per-register compare
//               mask table; a cleared mask bit excludes that bit.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_checker #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int REG_INDEX_BITS = 5,
    parameter int TEST_LENGTH    = 100
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      exp_wr_en,
    input  logic [REG_INDEX_BITS-1:0] exp_wr_index,
    input  logic [DATA_WIDTH-1:0]     exp_wr_data,
`ifdef CHECKER_MASK_EN
    input  logic [DATA_WIDTH-1:0]     exp_wr_mask,
`endif
    output logic [REG_INDEX_BITS-1:0] rf_read_index,
    input  logic [DATA_WIDTH-1:0]     rf_read_data,
    output logic                      mm_valid,
    input  logic                      mm_ready,
    output logic [REG_INDEX_BITS-1:0] mm_index,
    output logic [DATA_WIDTH-1:0]     mm_expected,
    output logic [DATA_WIDTH-1:0]     mm_actual,
    output logic                      busy,
    output logic                      done,
    output logic                      test_passed,
    output logic [REG_INDEX_BITS:0]   mm_count
);

    // Run counter only has to reach TEST_LENGTH-1
    localparam int c_cnt_w = (TEST_LENGTH > 1) ? $clog2(TEST_LENGTH) : 1;
    localparam logic [c_cnt_w-1:0]        c_cnt_last = c_cnt_w'(TEST_LENGTH - 1);
    localparam logic [REG_INDEX_BITS-1:0] c_last_idx = REG_INDEX_BITS'(NUM_REGS - 1);
    localparam logic [REG_INDEX_BITS:0]   c_num_regs = (REG_INDEX_BITS + 1)'(NUM_REGS);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_run    = 3'd1;
    localparam logic [2:0] c_st_scan   = 3'd2;
    localparam logic [2:0] c_st_report = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    logic [2:0]                r_state;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [REG_INDEX_BITS-1:0] r_scan_idx;
    logic                      r_mm_valid;
    logic [REG_INDEX_BITS-1:0] r_mm_index;
    logic [DATA_WIDTH-1:0]     r_mm_expected;
    logic [DATA_WIDTH-1:0]     r_mm_actual;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_test_passed;
    logic [REG_INDEX_BITS:0]   r_mm_count;

    logic [DATA_WIDTH-1:0]     r_exp_mem [NUM_REGS];

    logic                      w_idle_like;
    logic                      w_wr_ok;
    logic [DATA_WIDTH-1:0]     w_exp;
    logic [DATA_WIDTH-1:0]     w_diff;
    logic                      w_mismatch;
    logic                      w_last;

    // Table loads are accepted only while no run is in progress, and only
    // for indices that actually exist.
    assign w_idle_like = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_wr_ok     = exp_wr_en && w_idle_like && ({1'b0, exp_wr_index} < c_num_regs);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_exp_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_exp_mem[exp_wr_index] <= exp_wr_data;
        end
    end

    assign w_exp = r_exp_mem[r_scan_idx];

`ifdef CHECKER_MASK_EN
    logic [DATA_WIDTH-1:0] r_mask_mem [NUM_REGS];

    // Mask resets to all ones so an unloaded entry compares every bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mask_mem[i] <= '1;
            end
        end else if (w_wr_ok) begin
            r_mask_mem[exp_wr_index] <= exp_wr_mask;
        end
    end

    assign w_diff = (rf_read_data ^ w_exp) & r_mask_mem[r_scan_idx];
`else
    assign w_diff = rf_read_data ^ w_exp;
`endif

    assign w_mismatch    = |w_diff;
    assign w_last        = (r_scan_idx == c_last_idx);
    assign rf_read_index = (r_state == c_st_scan) ? r_scan_idx : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_scan_idx    <= '0;
            r_mm_valid    <= 1'b0;
            r_mm_index    <= '0;
            r_mm_expected <= '0;
            r_mm_actual   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_test_passed <= 1'b0;
            r_mm_count    <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_state       <= c_st_run;
                        r_cnt         <= '0;
                        r_mm_count    <= '0;
                        r_test_passed <= 1'b0;
                        r_done        <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                c_st_run: begin
                    // TEST_LENGTH cycles in RUN, then the scan starts at 0
                    if (r_cnt == c_cnt_last) begin
                        r_state    <= c_st_scan;
                        r_scan_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_scan: begin
                    if (w_mismatch) begin
                        r_state       <= c_st_report;
                        r_mm_valid    <= 1'b1;
                        r_mm_index    <= r_scan_idx;
                        r_mm_expected <= w_exp;
                        r_mm_actual   <= rf_read_data;
                        r_mm_count    <= r_mm_count + 1'b1;
                    end else if (w_last) begin
                        r_state       <= c_st_done;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_test_passed <= (r_mm_count == '0);
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                c_st_report: begin
                    if (mm_ready) begin
                        r_mm_valid <= 1'b0;
                        if (w_last) begin
                            // A report was issued, so this run has failed
                            r_state       <= c_st_done;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_test_passed <= 1'b0;
                        end else begin
                            r_state    <= c_st_scan;
                            r_scan_idx <= r_scan_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_mm_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mm_valid    = r_mm_valid;
    assign mm_index    = r_mm_index;
    assign mm_expected = r_mm_expected;
    assign mm_actual   = r_mm_actual;
    assign busy        = r_busy;
    assign done        = r_done;
    assign test_passed = r_test_passed;
    assign mm_count    = r_mm_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_checker
// Description : Directed self-checking bench for reg_file_checker. Models the
//               core register file and the expected table contents, drives
//               start/table loads/mm_ready and compares status, timing and
//               mismatch payloads with hand-computed values.
// Options     : build with CHECKER_MASK_EN to exercise the compare mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_checker;

    localparam int c_dw = 32;
    localparam int c_nr = 32;
    localparam int c_ib = 5;
    localparam int c_tl = 100;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              exp_wr_en = 1'b0;
    logic [c_ib-1:0]   exp_wr_index = '0;
    logic [c_dw-1:0]   exp_wr_data = '0;
`ifdef CHECKER_MASK_EN
    logic [c_dw-1:0]   exp_wr_mask = '1;
`endif
    logic [c_ib-1:0]   rf_read_index;
    logic [c_dw-1:0]   rf_read_data;
    logic              mm_valid;
    logic              mm_ready = 1'b0;
    logic [c_ib-1:0]   mm_index;
    logic [c_dw-1:0]   mm_expected;
    logic [c_dw-1:0]   mm_actual;
    logic              busy;
    logic              done;
    logic              test_passed;
    logic [c_ib:0]     mm_count;

    logic [c_dw-1:0]   rf_model  [c_nr];
    logic [c_dw-1:0]   exp_model [c_nr];

    int                n_checks = 0;
    int                n_errors = 0;
    bit                valid_seen = 1'b0;
    int                rpt_q [$];

    reg_file_checker #(
        .DATA_WIDTH    (c_dw),
        .NUM_REGS      (c_nr),
        .REG_INDEX_BITS(c_ib),
        .TEST_LENGTH   (c_tl)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .exp_wr_en    (exp_wr_en),
        .exp_wr_index (exp_wr_index),
        .exp_wr_data  (exp_wr_data),
`ifdef CHECKER_MASK_EN
        .exp_wr_mask  (exp_wr_mask),
`endif
        .rf_read_index(rf_read_index),
        .rf_read_data (rf_read_data),
        .mm_valid     (mm_valid),
        .mm_ready     (mm_ready),
        .mm_index     (mm_index),
        .mm_expected  (mm_expected),
        .mm_actual    (mm_actual),
        .busy         (busy),
        .done         (done),
        .test_passed  (test_passed),
        .mm_count     (mm_count)
    );

    always #5 clock = ~clock;

    // Combinational core register file model
    assign rf_read_data = rf_model[rf_read_index];

    // Observe handshakes mid-cycle, away from the active edge
    always @(negedge clock) begin
        if (!reset && mm_valid) begin
            valid_seen = 1'b1;
            if (mm_ready) rpt_q.push_back(int'(mm_index));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_exp(input int idx, input logic [c_dw-1:0] data);
        @(posedge clock); #1;
        exp_wr_en    = 1'b1;
        exp_wr_index = c_ib'(idx);
        exp_wr_data  = data;
        @(posedge clock); #1;
        exp_wr_en    = 1'b0;
    endtask

    // Returns positioned 1 time unit after the edge that samples start
    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Counts edges until done; optional stray start at cycle restart_at
    task automatic run_until_done(input int limit, input int restart_at, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            start = (cycles == restart_at);
            @(posedge clock); #1;
            cycles++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit && !mm_valid) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;
        logic [c_ib-1:0] p_idx;
        logic [c_dw-1:0] p_exp, p_act;

        for (int i = 0; i < c_nr; i++) begin
            rf_model[i]  = '0;
            exp_model[i] = '0;
        end

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_passed", test_passed, 0);
        check("rst_valid", mm_valid, 0);
        check("rst_count", mm_count, 0);
        check("rst_rdidx", rf_read_index, 0);
        check("rst_payload", {mm_index, mm_expected, mm_actual}, 0);
        reset = 1'b0;

        // ---------------- clean run ----------------
        write_exp(11, 32'h0000_1000); exp_model[11] = 32'h0000_1000;
        write_exp(12, 32'h8000_0000); exp_model[12] = 32'h8000_0000;
        write_exp(16, 32'h0000_1001); exp_model[16] = 32'h0000_1001;
        for (int i = 0; i < c_nr; i++) rf_model[i] = exp_model[i];
        valid_seen = 1'b0;
        pulse_start();
        check("a_busy", busy, 1);
        run_until_done(400, -1, cyc);
        check("a_done_cycles", cyc, 132);
        check("a_passed", test_passed, 1);
        check("a_count", mm_count, 0);
        check("a_no_valid", valid_seen, 0);
        repeat (4) @(posedge clock);
        #1;
        check("a_done_held", {done, test_passed, busy}, 3'b110);
        check("a_rdidx_idle", rf_read_index, 0);

        // ---------------- single mismatch, stalled report ----------------
        rf_model[13] = 32'hFFFF_F000;
        mm_ready = 1'b0;
        pulse_start();
        write_exp(5, 32'h0000_DEAD);   // busy: must be ignored
        wait_valid(300, cyc);
        check("b_valid_cycles", cyc + 2, 114);
        check("b_index", mm_index, 13);
        check("b_expected", mm_expected, 0);
        check("b_actual", mm_actual, 32'hFFFF_F000);
        check("b_count", mm_count, 1);
        p_idx = mm_index; p_exp = mm_expected; p_act = mm_actual;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            if (!mm_valid || mm_index != p_idx || mm_expected != p_exp || mm_actual != p_act) bad++;
        end
        check("b_stable", bad, 0);
        mm_ready = 1'b1;
        run_until_done(300, -1, cyc);
        mm_ready = 1'b0;
        check("b_done", done, 1);
        check("b_passed", test_passed, 0);
        check("b_count_end", mm_count, 1);

        // ---------------- every register mismatched ----------------
        for (int i = 0; i < c_nr; i++) rf_model[i] = exp_model[i] ^ 32'h1;
        mm_ready = 1'b1;
        rpt_q.delete();
        pulse_start();
        run_until_done(400, -1, cyc);
        check("c_done_cycles", cyc, 164);
        check("c_count", mm_count, 32);
        check("c_reports", rpt_q.size(), 32);
        bad = 0;
        for (int i = 0; i < rpt_q.size(); i++) if (rpt_q[i] != i) bad++;
        check("c_order", bad, 0);
        check("c_passed", test_passed, 0);
        mm_ready = 1'b0;

        // ---------------- stray start during RUN ----------------
        for (int i = 0; i < c_nr; i++) rf_model[i] = exp_model[i];
        pulse_start();
        run_until_done(400, 50, cyc);
        check("d_done_cycles", cyc, 132);
        check("d_passed", test_passed, 1);

        // ---------------- reset mid-REPORT ----------------
        rf_model[13] = 32'hFFFF_F000;
        pulse_start();
        wait_valid(300, cyc);
        check("d_in_report", mm_valid, 1);
        reset = 1'b1;
        #1;
        check("d_rst_status", {busy, done, test_passed, mm_valid}, 0);
        check("d_rst_count", mm_count, 0);
        check("d_rst_payload", {rf_read_index, mm_index, mm_expected, mm_actual}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < c_nr; i++) begin
            exp_model[i] = '0;
            rf_model[i]  = '0;
        end

        // ---------------- compare mask ----------------
        rf_model[12] = 32'h8000_0000;
`ifdef CHECKER_MASK_EN
        exp_wr_mask = 32'h7FFF_FFFF;
        write_exp(12, 32'h0);
        exp_wr_mask = '1;
        pulse_start();
        run_until_done(400, -1, cyc);
        check("e_done_cycles", cyc, 132);
        check("e_passed", test_passed, 1);
        check("e_count", mm_count, 0);
`else
        mm_ready = 1'b1;
        rpt_q.delete();
        pulse_start();
        run_until_done(400, -1, cyc);
        check("e_done", done, 1);
        check("e_passed", test_passed, 0);
        check("e_count", mm_count, 1);
        check("e_reports", rpt_q.size(), 1);
        check("e_index", (rpt_q.size() > 0) ? rpt_q[0] : -1, 12);
        mm_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
